ps2_rx_fifo: RTL
================

Name: ps2_rx_fifo

Overview:
- Parametrised PS/2 device-to-host receiver: synchronises and de-glitches `ps2_clk`, shifts 11-bit frames and checks start, stop and odd parity.
- Valid scan codes are pushed into a power-of-two FIFO that the CPU or keyboard-controller side drains.
- Adds over the previous receiver: configurable depth, glitch filter, mid-frame timeout resync, sticky error flags, FIFO level output, and optional E0/F0 prefix folding.
- Sits between the PS/2 pins and the keyboard/ASCII translation logic.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- FILTER_LEN, 4, consecutive equal `ps2_clk` samples required before the filtered clock changes state.
- TIMEOUT_CYC, 100000, idle `clk` cycles allowed between falling edges inside a frame (2 ms at 50 MHz).

Ports:
- `clk`  in  1  system clock.
- `clrn`  in  1  synchronous active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock pin.
- `ps2_data`  in  1  raw PS/2 data pin.
- `nextdata_n`  in  1  active-low pop strobe.
- `clr_err`  in  1  active-high one-cycle pulse; clears sticky flags.
- `data`  out  8  scan code at FIFO head.
- `ready`  out  1  FIFO non-empty.
- `level`  out  $clog2(DEPTH)+1  current entry count.
- `overflow`  out  1  sticky: a frame was dropped because the FIFO was full.
- `parity_err`  out  1  sticky: a frame failed the parity check.
- `frame_err`  out  1  sticky: bad start bit, bad stop bit, or timeout.
- `brk`  out  1  head entry was preceded by F0 (macro only; else 0).
- `ext`  out  1  head entry was preceded by E0 (macro only; else 0).

Behaviour:
- Reset: `clrn` low at a `clk` edge clears everything below. Reset is synchronous and active-low; there is no async path.
  - Pointers, `level`, bit counter, timeout counter and prefix state go to 0.
  - Filtered clock goes to 1. Synchronisers go to all-ones (idle bus).
  - `ready`, `overflow`, `parity_err`, `frame_err`, `brk`, `ext` go to 0.
  - FIFO contents are not cleared.
  - Reset mid-frame discards the partial frame.
- Input path:
  - `ps2_clk` and `ps2_data` each pass a 3-flop synchroniser of equal depth, so they stay aligned.
  - The filtered clock takes the synchronised value only after FILTER_LEN consecutive identical samples.
  - `sample` = one-cycle pulse on a 1→0 transition of the filtered clock.
- Frame FSM, states IDLE, SHIFT, CHECK:
  - IDLE: on `sample`, store bit 0 (start) and go to SHIFT with count = 1.
  - SHIFT: on each `sample`, store bit[count] and increment. After bit 9 (parity) is stored, the next `sample` captures the stop bit and enters CHECK.
  - CHECK lasts one cycle:
    - start == 0, stop == 1 and XOR(bits 9:1) == 1 → push bits 8:1.
    - Parity failure → set `parity_err`, no push.
    - Start or stop failure → set `frame_err`, no push.
    - Always return to IDLE.
  - Timeout: in SHIFT, a counter clears on every `sample` and increments otherwise. On reaching TIMEOUT_CYC, set `frame_err` and go to IDLE. This resyncs after a lost edge.
- FIFO:
  - `data` = entry at the read pointer, combinational.
  - `ready` = (`level` != 0).
  - Pop: `nextdata_n` == 0 and `ready` → read pointer +1 on that edge. Level-sensitive, one entry per cycle while held low. Pop when empty is ignored.
  - Push when not full → write, write pointer +1.
  - Push when full with no simultaneous pop → byte dropped, `overflow` set.
  - Push and pop in the same cycle → both take effect and `level` is unchanged, including the full case (no overflow).
  - Pointers wrap modulo DEPTH. `level` is updated with `ready` in the same cycle.
- Latency: a push is visible on `ready`/`data` 1 cycle after CHECK. CHECK is 1 cycle after the `sample` of the stop bit.
- Sticky flags clear on `clr_err` or reset. A set event in the same cycle as `clr_err` wins.

Optional Feature:
- Macro: PS2_CODE_DECODE_EN.
- Defined:
  - FIFO entries are 10 bits: {ext, brk, code}.
  - A valid 0xE0 byte is not pushed; it sets pending_ext. A valid 0xF0 byte is not pushed; it sets pending_brk.
  - The next other valid byte is pushed with the pending flags, then both pending flags clear.
  - Pending flags also clear on `parity_err`/`frame_err` events, on reset, and when that push is dropped by overflow.
  - `brk`/`ext` reflect the head entry.
- Undefined:
  - 8-bit entries; every valid byte is pushed raw, including E0 and F0.
  - `brk`/`ext` tied to 0.

Test Plan:
- Frame 0x1C, parity 0, stop 1 → `ready`=1, `data`=0x1C, `level`=1. Pulse `nextdata_n` low for 1 cycle → `ready`=0, `level`=0.
- Frame 0x1C with parity 1 → `parity_err`=1, `ready` stays 0. Then `clr_err` pulse → `parity_err`=0.
- 5 falling edges, then idle TIMEOUT_CYC+10 cycles → `frame_err`=1. Next full frame 0x32 → `data`=0x32, `level`=1.
- DEPTH=8, 9 frames 0x01..0x09 with no pop → `level`=8, `overflow`=1; pops return 0x01..0x08. Frame arriving with `level`=8 and `nextdata_n` low in CHECK cycle → `overflow` stays 0.
- `ps2_clk` low glitch of FILTER_LEN-1 cycles between frames → no `sample`, FSM stays IDLE, `level` unchanged.
- Macro defined: frames E0, F0, 0x74 → `level`=1, `data`=0x74, `ext`=1, `brk`=1. Then frame 0x1C → second entry has `ext`=0, `brk`=0.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with glitch filter, frame timeout, sticky errors and a scan-code FIFO.
// Optional E0/F0 prefix folding into FIFO entries when PS2_CODE_DECODE_EN is defined.
module ps2_rx_fifo #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic                      clk,
    input  logic                      clrn,
    input  logic                      ps2_clk,
    input  logic                      ps2_data,
    input  logic                      nextdata_n,
    input  logic                      clr_err,
    output logic [7:0]                data,
    output logic                      ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic                      parity_err,
    output logic                      frame_err,
    output logic                      brk,
    output logic                      ext
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned FW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
`ifdef PS2_CODE_DECODE_EN
    localparam int unsigned EW = 10;
`else
    localparam int unsigned EW = 8;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    logic [2:0]    r_clk_sync;
    logic [2:0]    r_dat_sync;
    logic          r_filt;
    logic          r_filt_d;
    logic [FW-1:0] r_filt_cnt;
    logic          w_clk_s;
    logic          w_data_s;
    logic          w_sample;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [10:0]   r_frame;
    logic [10:0]   w_frame_nxt;
    logic [3:0]    r_bit_cnt;
    logic [3:0]    w_bit_cnt_nxt;
    logic [TW-1:0] r_to_cnt;
    logic [TW-1:0] w_to_cnt_nxt;
    logic          w_valid;
    logic          w_perr_ev;
    logic          w_ferr_ev;

    logic          w_push;
    logic [EW-1:0] w_wdata;
    logic [7:0]    w_byte;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_overflow;
    logic          r_parity_err;
    logic          r_frame_err;
    logic          w_full;
    logic          w_pop;
    logic          w_wr_en;
    logic          w_ovf_ev;
    logic [EW-1:0] w_head;

    // Equal-depth synchronisers keep clock and data aligned
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 3'b111;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[1:0], ps2_data};
        end
    end

    assign w_clk_s  = r_clk_sync[2];
    assign w_data_s = r_dat_sync[2];

    // Filtered clock flips only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_filt     <= 1'b1;
            r_filt_d   <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_filt_d <= r_filt;
            if (w_clk_s == r_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_filt     <= w_clk_s;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + FW'(1);
            end
        end
    end

    assign w_sample = r_filt_d & ~r_filt;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state   <= S_IDLE;
            r_frame   <= '0;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_frame   <= w_frame_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
        end
    end

    // Frame FSM: start bit, 8 data, odd parity, stop; timeout resyncs on a lost edge
    always_comb begin
        w_state_nxt   = r_state;
        w_frame_nxt   = r_frame;
        w_bit_cnt_nxt = r_bit_cnt;
        w_to_cnt_nxt  = '0;
        w_valid       = 1'b0;
        w_perr_ev     = 1'b0;
        w_ferr_ev     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sample) begin
                    w_frame_nxt[0] = w_data_s;
                    w_bit_cnt_nxt  = 4'd1;
                    w_state_nxt    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_sample) begin
                    w_frame_nxt[r_bit_cnt] = w_data_s;
                    w_bit_cnt_nxt          = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd10) begin
                        w_state_nxt = S_CHECK;
                    end
                end else if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    w_ferr_ev     = 1'b1;
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TW'(1);
                end
            end
            S_CHECK: begin
                w_ferr_ev     = r_frame[0] | ~r_frame[10];
                w_perr_ev     = ~(^r_frame[9:1]);
                w_valid       = ~w_ferr_ev & ~w_perr_ev;
                w_bit_cnt_nxt = '0;
                w_state_nxt   = S_IDLE;
            end
            default: begin
                w_bit_cnt_nxt = '0;
                w_state_nxt   = S_IDLE;
            end
        endcase
    end

    assign w_byte = r_frame[8:1];

`ifdef PS2_CODE_DECODE_EN
    logic r_pend_ext;
    logic r_pend_brk;
    logic w_is_e0;
    logic w_is_f0;

    assign w_is_e0 = w_valid && (w_byte == 8'hE0);
    assign w_is_f0 = w_valid && (w_byte == 8'hF0);
    assign w_push  = w_valid & ~w_is_e0 & ~w_is_f0;
    assign w_wdata = {r_pend_ext, r_pend_brk, w_byte};

    // Prefix bytes fold into flags carried by the next real code
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_pend_ext <= 1'b0;
            r_pend_brk <= 1'b0;
        end else if (w_perr_ev || w_ferr_ev || w_push) begin
            r_pend_ext <= 1'b0;
            r_pend_brk <= 1'b0;
        end else begin
            if (w_is_e0) r_pend_ext <= 1'b1;
            if (w_is_f0) r_pend_brk <= 1'b1;
        end
    end

    assign brk = w_head[8];
    assign ext = w_head[9];
`else
    assign w_push  = w_valid;
    assign w_wdata = w_byte;
    assign brk     = 1'b0;
    assign ext     = 1'b0;
`endif

    assign w_full   = (r_level == LW'(DEPTH));
    assign w_pop    = ~nextdata_n & (r_level != '0);
    assign w_wr_en  = w_push & (~w_full | w_pop);
    assign w_ovf_ev = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (clrn && w_wr_en) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr_en, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky flags: a new event outranks a same-cycle clear
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_overflow   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_overflow   <= w_ovf_ev  | (r_overflow   & ~clr_err);
            r_parity_err <= w_perr_ev | (r_parity_err & ~clr_err);
            r_frame_err  <= w_ferr_ev | (r_frame_err  & ~clr_err);
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign data       = w_head[7:0];
    assign ready      = (r_level != '0);
    assign level      = r_level;
    assign overflow   = r_overflow;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;

endmodule
